adc_fifo_packer: RTL and testbench
==================================

Name: adc_fifo_packer

Overview:
- Write-side companion to the USB register FIFO reader: takes ADC samples, packs them into bytes, and writes them into the byte-wide ADC capture FIFO that USB later drains.
- Honours the same low_res / low_res_lsb / stream_segment_size settings as the read side.
- Produces the sticky error byte the read side reports as FIFO_STAT[7:0], cleared by the read side's clear_fifo_errors pulse.
- Sits in the ADC clock domain, between the ADC capture front end and the capture FIFO write port.

Parameters:
pADC_BITS, 12, ADC sample width; packing logic supports exactly 12.
pQUEUE_DEPTH, 4, internal byte-queue entries; power of two, at least 2.

Ports:
clk_adc  input  1  ADC-domain clock; all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
arm_i  input  1  level; high = capture enabled.
adc_data  input  pADC_BITS  sample.
adc_valid  input  1  sample qualifier; at most one sample per cycle.
low_res  input  1  1 = one byte per sample.
low_res_lsb  input  1  with low_res: 1 = adc_data[7:0], 0 = adc_data[11:4].
stream_segment_size  input  32  bytes per segment; 0 = segmenting off.
clear_fifo_errors  input  1  one-cycle pulse; clears the error byte.
fifo_full  input  1  capture FIFO full.
fifo_wr_en  output  1  FIFO write strobe.
fifo_wr_data  output  8  FIFO write byte.
fifo_error_stat  output  8  sticky error flags.
segment_done  output  1  one-cycle pulse at each segment boundary.
bytes_written  output  32  bytes written since arm; wraps at 2^32.

Behaviour:
- Reset (async assert, sync release): state IDLE, queue empty, residue 0; fifo_wr_en 0, fifo_wr_data 0, fifo_error_stat 0, segment_done 0, bytes_written 0.
- Mode latch:
  - low_res and low_res_lsb are latched on the IDLE->ARMED transition.
  - Changes while armed are ignored.
- State machine:
  - IDLE: on arm_i=1 -> EVEN; clear bytes_written and the segment counter.
  - EVEN: accepted sample A, 12-bit mode: push A[11:7-4] i.e. A[11:4] (1 byte), store residue A[3:0], -> ODD.
  - ODD: accepted sample B, 12-bit mode: push {residue, B[11:8]} then B[7:0] (2 bytes, same cycle), -> EVEN.
  - Low-res mode: every accepted sample pushes 1 byte and the state stays EVEN.
  - arm_i=0 in EVEN -> DRAIN.
  - arm_i=0 in ODD -> push {residue, 4'b0} when the queue has a free entry, then -> DRAIN. The pad byte counts as written.
  - DRAIN: no samples accepted; -> IDLE once the queue is empty.
- Acceptance:
  - A sample is accepted only if free queue entries are at least the bytes it needs.
  - Otherwise the sample is dropped and the state does not advance.
  - Drop while fifo_full=1 sets fifo_error_stat[0] (back-pressure overflow).
  - Drop while fifo_full=0 sets fifo_error_stat[1] (rate overrun; 12-bit mode sustains at most 2 samples per 3 cycles).
  - A valid sample in IDLE or DRAIN sets fifo_error_stat[2].
  - fifo_error_stat[7:3] always 0.
- Error flags: sticky. clear_fifo_errors zeroes them; a set in the same cycle as a clear wins.
- Write port:
  - fifo_wr_en is registered: asserted in cycle N+1 when the queue is non-empty and fifo_full=0 at cycle N. fifo_wr_data = head byte.
  - One pop per cycle; bytes are never lost once queued.
  - A queue push and pop in the same cycle are both honoured.
  - Latency: low-res sample accepted at cycle N, queue and FIFO not full -> fifo_wr_en in cycle N+1.
- Counters:
  - bytes_written increments on each fifo_wr_en.
  - The segment counter increments on each write. When it reaches stream_segment_size (non-zero), segment_done pulses in the same cycle as that write and the counter returns to 0.
  - A size change mid-segment takes effect on the next comparison. Equality compare only, so reducing the size below the current count defers the boundary to wrap.
- Reset mid-operation: everything returns to reset values immediately; queued bytes are discarded.

Decomposition:
- Shared package: state encoding (IDLE, EVEN, ODD, DRAIN); error bit indices FERR_FULL_DROP=0, FERR_OVERRUN=1, FERR_IDLE_SAMPLE=2.
- One sub-module: adc_byte_queue, a pQUEUE_DEPTH entry, two-push / one-pop byte queue with free-count output.

Test Plan:
- Low-res MSB: arm; samples 0xABC, 0x123 on consecutive cycles -> bytes 0xAB, 0x12; bytes_written=2.
- 12-bit packing: samples 0xABC, 0x123 spaced 2 cycles apart -> bytes 0xAB, 0xC1, 0x23; no error bits set.
- Odd-count flush: arm; one sample 0x5A7; drop arm_i -> bytes 0x5A, 0x70; state returns to IDLE.
- Back-pressure: hold fifo_full=1, feed 5 low-res samples -> 4 queued, 5th dropped, fifo_error_stat=0x01. Release fifo_full -> 4 bytes written in order.
- Rate overrun: 12-bit samples every cycle for 8 cycles -> fifo_error_stat[1]=1. Pulse clear_fifo_errors -> 0x00. Same-cycle new drop and clear -> bit remains 1.
- Segments: stream_segment_size=3, write 7 low-res bytes -> segment_done on writes 3 and 6. Async reset asserted mid-stream -> all outputs 0 within the reset cycle.

Source files
------------

// File: rtl/adc_fifo_packer_pkg.sv
// adc_fifo_packer_pkg
//   Types and constants shared by the ADC write-side byte packer:
//   FSM state encoding and bit positions inside the sticky error byte.
package adc_fifo_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVEN  = 2'd1,
        ST_ODD   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int unsigned FERR_FULL_DROP   = 0;
    localparam int unsigned FERR_OVERRUN     = 1;
    localparam int unsigned FERR_IDLE_SAMPLE = 2;

endpackage

// File: rtl/adc_byte_queue.sv
// adc_byte_queue
//   Small byte queue: up to two pushes and one pop per cycle.
//   Ports:
//     clk_adc, reset_n  : clock, async active-low reset
//     i_push_cnt        : number of bytes pushed this cycle (0..2)
//     i_push_d0/d1      : pushed bytes, d0 enters first
//     i_pop             : remove head byte (only while o_avail)
//     o_head            : head byte (bypasses d0 when the queue is empty)
//     o_avail           : a byte can be popped this cycle
//     o_free            : free entries, before this cycle's push/pop
module adc_byte_queue #(
    parameter int pQUEUE_DEPTH = 4
) (
    input  logic                            clk_adc,
    input  logic                            reset_n,
    input  logic [1:0]                      i_push_cnt,
    input  logic [7:0]                      i_push_d0,
    input  logic [7:0]                      i_push_d1,
    input  logic                            i_pop,
    output logic [7:0]                      o_head,
    output logic                            o_avail,
    output logic [$clog2(pQUEUE_DEPTH):0]   o_free
);
    localparam int unsigned AW = $clog2(pQUEUE_DEPTH);

    logic [7:0]    r_mem [pQUEUE_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_empty;
    logic [AW-1:0] w_wr_ptr1;

    assign w_empty   = (r_count == '0);
    assign w_wr_ptr1 = r_wr_ptr + AW'(1);
    // An empty queue forwards the byte being pushed so a lone byte leaves
    // on the cycle after it was accepted.
    assign o_avail   = !w_empty || (i_push_cnt != 2'd0);
    assign o_head    = w_empty ? i_push_d0 : r_mem[r_rd_ptr];
    assign o_free    = (AW+1)'(pQUEUE_DEPTH) - r_count;

    always_ff @(posedge clk_adc) begin
        if (i_push_cnt != 2'd0) r_mem[r_wr_ptr]  <= i_push_d0;
        if (i_push_cnt == 2'd2) r_mem[w_wr_ptr1] <= i_push_d1;
    end

    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push_cnt);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_count  <= r_count + (AW+1)'(i_push_cnt) - (AW+1)'(i_pop);
        end
    end

endmodule

// File: rtl/adc_fifo_packer.sv
// adc_fifo_packer
//   Packs ADC samples into bytes and writes them into the capture FIFO.
//   12-bit mode: two samples -> three bytes; low-res mode: one byte/sample.
//   Ports:
//     clk_adc, reset_n        : clock, async active-low reset
//     arm_i                   : capture enable level
//     adc_data, adc_valid     : sample and qualifier
//     low_res, low_res_lsb    : packing mode (latched at arm)
//     stream_segment_size     : bytes per segment, 0 = off
//     clear_fifo_errors       : pulse clearing the sticky error byte
//     fifo_full               : capture FIFO full
//     fifo_wr_en/fifo_wr_data : FIFO write port
//     fifo_error_stat         : sticky error flags
//     segment_done            : pulse with the write ending a segment
//     bytes_written           : bytes written since arm
module adc_fifo_packer
    import adc_fifo_packer_pkg::*;
#(
    parameter int pADC_BITS    = 12,
    parameter int pQUEUE_DEPTH = 4
) (
    input  logic                 clk_adc,
    input  logic                 reset_n,
    input  logic                 arm_i,
    input  logic [pADC_BITS-1:0] adc_data,
    input  logic                 adc_valid,
    input  logic                 low_res,
    input  logic                 low_res_lsb,
    input  logic [31:0]          stream_segment_size,
    input  logic                 clear_fifo_errors,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [7:0]           fifo_wr_data,
    output logic [7:0]           fifo_error_stat,
    output logic                 segment_done,
    output logic [31:0]          bytes_written
);
    localparam int unsigned QAW = $clog2(pQUEUE_DEPTH);

    state_t      r_state;
    logic        r_low_res;
    logic        r_lsb;
    logic [3:0]  r_residue;
    logic        r_wr_en;
    logic [7:0]  r_wr_data;
    logic [2:0]  r_err;
    logic        r_seg_done;
    logic [31:0] r_bytes;
    logic [31:0] r_seg_cnt;

    state_t      w_state_nxt;
    logic [1:0]  w_push_cnt;
    logic [7:0]  w_d0;
    logic [7:0]  w_d1;
    logic [2:0]  w_set_err;
    logic        w_res_ld;
    logic        w_arm_start;
    logic        w_pop;
    logic        w_avail;
    logic [7:0]  w_head;
    logic [QAW:0] w_free;
    logic        w_fits1;
    logic        w_fits2;
    logic [31:0] w_seg_nxt;

    adc_byte_queue #(
        .pQUEUE_DEPTH (pQUEUE_DEPTH)
    ) u_queue (
        .clk_adc    (clk_adc),
        .reset_n    (reset_n),
        .i_push_cnt (w_push_cnt),
        .i_push_d0  (w_d0),
        .i_push_d1  (w_d1),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_avail    (w_avail),
        .o_free     (w_free)
    );

    assign w_fits1     = (w_free != '0);
    assign w_fits2     = (w_free >= (QAW+1)'(2));
    assign w_pop       = w_avail && !fifo_full;
    assign w_arm_start = (r_state == ST_IDLE) && arm_i;
    assign w_seg_nxt   = r_seg_cnt + 32'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_push_cnt  = 2'd0;
        w_d0        = 8'h00;
        w_d1        = 8'h00;
        w_set_err   = 3'b000;
        w_res_ld    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (adc_valid) w_set_err[FERR_IDLE_SAMPLE] = 1'b1;
                if (arm_i)     w_state_nxt = ST_EVEN;
            end
            ST_EVEN: begin
                if (!arm_i) begin
                    w_state_nxt = ST_DRAIN;
                end else if (adc_valid) begin
                    if (w_fits1) begin
                        w_push_cnt = 2'd1;
                        if (r_low_res) begin
                            w_d0 = r_lsb ? adc_data[7:0] : adc_data[11:4];
                        end else begin
                            w_d0        = adc_data[11:4];
                            w_res_ld    = 1'b1;
                            w_state_nxt = ST_ODD;
                        end
                    end else if (fifo_full) begin
                        w_set_err[FERR_FULL_DROP] = 1'b1;
                    end else begin
                        w_set_err[FERR_OVERRUN] = 1'b1;
                    end
                end
            end
            ST_ODD: begin
                if (!arm_i) begin
                    // Flush the dangling nibble as a zero-padded byte.
                    if (w_fits1) begin
                        w_push_cnt  = 2'd1;
                        w_d0        = {r_residue, 4'h0};
                        w_state_nxt = ST_DRAIN;
                    end
                end else if (adc_valid) begin
                    if (w_fits2) begin
                        w_push_cnt  = 2'd2;
                        w_d0        = {r_residue, adc_data[11:8]};
                        w_d1        = adc_data[7:0];
                        w_state_nxt = ST_EVEN;
                    end else if (fifo_full) begin
                        w_set_err[FERR_FULL_DROP] = 1'b1;
                    end else begin
                        w_set_err[FERR_OVERRUN] = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (adc_valid) w_set_err[FERR_IDLE_SAMPLE] = 1'b1;
                if (!w_avail)  w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_low_res  <= 1'b0;
            r_lsb      <= 1'b0;
            r_residue  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_err      <= '0;
            r_seg_done <= 1'b0;
            r_bytes    <= '0;
            r_seg_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arm_start) begin
                r_low_res <= low_res;
                r_lsb     <= low_res_lsb;
            end
            if (w_res_ld) r_residue <= adc_data[3:0];
            r_wr_en <= w_pop;
            if (w_pop) r_wr_data <= w_head;
            // A new error in the clearing cycle survives the clear.
            r_err      <= (clear_fifo_errors ? 3'b000 : r_err) | w_set_err;
            r_seg_done <= 1'b0;
            if (w_arm_start) begin
                r_bytes   <= '0;
                r_seg_cnt <= '0;
            end else if (w_pop) begin
                r_bytes <= r_bytes + 32'd1;
                if ((stream_segment_size != 32'd0) && (w_seg_nxt == stream_segment_size)) begin
                    r_seg_done <= 1'b1;
                    r_seg_cnt  <= '0;
                end else begin
                    r_seg_cnt <= w_seg_nxt;
                end
            end
        end
    end

    assign fifo_wr_en      = r_wr_en;
    assign fifo_wr_data    = r_wr_data;
    assign fifo_error_stat = {5'b00000, r_err};
    assign segment_done    = r_seg_done;
    assign bytes_written   = r_bytes;

endmodule

// File: tb/tb_adc_fifo_packer.sv
// tb_adc_fifo_packer
//   Self-checking bench for adc_fifo_packer. A monitor collects every byte
//   written to the FIFO; each test builds the expected byte stream from the
//   packing rules and compares.
module tb_adc_fifo_packer;

    logic        clk_adc = 1'b0;
    logic        reset_n;
    logic        arm_i;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        low_res;
    logic        low_res_lsb;
    logic [31:0] stream_segment_size;
    logic        clear_fifo_errors;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [7:0]  fifo_error_stat;
    logic        segment_done;
    logic [31:0] bytes_written;

    int errors = 0;
    int checks = 0;

    logic [7:0]  got_q[$];
    bit          seg_q[$];
    int          orphan_seg = 0;
    logic [11:0] acc_q[$];
    logic [7:0]  exp_q[$];

    adc_fifo_packer #(
        .pADC_BITS    (12),
        .pQUEUE_DEPTH (4)
    ) dut (
        .clk_adc             (clk_adc),
        .reset_n             (reset_n),
        .arm_i               (arm_i),
        .adc_data            (adc_data),
        .adc_valid           (adc_valid),
        .low_res             (low_res),
        .low_res_lsb         (low_res_lsb),
        .stream_segment_size (stream_segment_size),
        .clear_fifo_errors   (clear_fifo_errors),
        .fifo_full           (fifo_full),
        .fifo_wr_en          (fifo_wr_en),
        .fifo_wr_data        (fifo_wr_data),
        .fifo_error_stat     (fifo_error_stat),
        .segment_done        (segment_done),
        .bytes_written       (bytes_written)
    );

    always #5 clk_adc = ~clk_adc;

    always @(negedge clk_adc) begin
        if (reset_n) begin
            if (fifo_wr_en) begin
                got_q.push_back(fifo_wr_data);
                seg_q.push_back(segment_done);
            end else if (segment_done) begin
                orphan_seg++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_adc);
        #1;
    endtask

    // Expected FIFO byte stream for the samples in acc_q: low-res takes one
    // byte per sample; 12-bit mode concatenates samples into a bit stream,
    // padding an odd trailing sample with a zero nibble.
    task automatic model_pack(input bit lr, input bit lsb);
        logic [23:0] p;
        logic [15:0] h;
        exp_q.delete();
        if (lr) begin
            foreach (acc_q[i]) begin
                p = {12'h000, acc_q[i]};
                exp_q.push_back(lsb ? p[7:0] : p[11:4]);
            end
        end else begin
            for (int i = 0; i < acc_q.size(); i += 2) begin
                if (i + 1 < acc_q.size()) begin
                    p = {acc_q[i], acc_q[i+1]};
                    exp_q.push_back(p[23:16]);
                    exp_q.push_back(p[15:8]);
                    exp_q.push_back(p[7:0]);
                end else begin
                    h = {acc_q[i], 4'h0};
                    exp_q.push_back(h[15:8]);
                    exp_q.push_back(h[7:0]);
                end
            end
        end
    endtask

    task automatic do_arm(input bit lr, input bit lsb);
        got_q.delete();
        seg_q.delete();
        low_res     = lr;
        low_res_lsb = lsb;
        arm_i       = 1'b1;
        tick();
        // Mode is latched; flipping it now must have no effect.
        low_res     = ~lr;
        low_res_lsb = ~lsb;
    endtask

    task automatic drive_one(input logic [11:0] s);
        adc_data  = s;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic disarm_wait();
        arm_i = 1'b0;
        repeat (12) tick();
    endtask

    task automatic pulse_clear();
        clear_fifo_errors = 1'b1;
        tick();
        clear_fifo_errors = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk_adc);
        #2 reset_n = 1'b1;
        tick();
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
        checks++; if (fifo_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h want 00", fifo_wr_data); end
        checks++; if (fifo_error_stat !== 8'h00) begin errors++; $display("FAIL reset_err: got %h want 00", fifo_error_stat); end
        checks++; if (segment_done !== 1'b0) begin errors++; $display("FAIL reset_seg: got %b want 0", segment_done); end
        checks++; if (bytes_written !== 32'd0) begin errors++; $display("FAIL reset_bytes: got %0d want 0", bytes_written); end
    endtask

    task automatic test_lowres(input bit lsb);
        int n;
        acc_q.delete();
        acc_q.push_back(12'hABC);
        acc_q.push_back(12'h123);
        n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) acc_q.push_back(12'($urandom_range(0, 4095)));
        stream_segment_size = 32'd0;
        do_arm(1'b1, lsb);
        foreach (acc_q[i]) drive_one(acc_q[i]);
        disarm_wait();
        model_pack(1'b1, lsb);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL lowres%0d_count: got %0d want %0d", lsb, got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL lowres%0d_byte%0d: got %h want %h", lsb, k, got_q[k], exp_q[k]);
            end
            checks++;
            if (seg_q[k] !== 1'b0) begin
                errors++; $display("FAIL lowres%0d_seg%0d: got 1 want 0", lsb, k);
            end
        end
        checks++;
        if (bytes_written !== 32'(exp_q.size())) begin
            errors++; $display("FAIL lowres%0d_bytes_written: got %0d want %0d", lsb, bytes_written, exp_q.size());
        end
        checks++;
        if (fifo_error_stat !== 8'h00) begin
            errors++; $display("FAIL lowres%0d_err: got %h want 00", lsb, fifo_error_stat);
        end
    endtask

    task automatic test_pack12();
        int n;
        acc_q.delete();
        acc_q.push_back(12'hABC);
        acc_q.push_back(12'h123);
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) acc_q.push_back(12'($urandom_range(0, 4095)));
        do_arm(1'b0, 1'b0);
        foreach (acc_q[i]) begin
            drive_one(acc_q[i]);
            tick();
        end
        disarm_wait();
        model_pack(1'b0, 1'b0);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL pack12_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL pack12_byte%0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
        checks++;
        if (fifo_error_stat !== 8'h00) begin
            errors++; $display("FAIL pack12_err: got %h want 00", fifo_error_stat);
        end
        checks++;
        if (bytes_written !== 32'(exp_q.size())) begin
            errors++; $display("FAIL pack12_bytes_written: got %0d want %0d", bytes_written, exp_q.size());
        end
    endtask

    task automatic test_odd_flush();
        do_arm(1'b0, 1'b0);
        drive_one(12'h5A7);
        disarm_wait();
        checks++;
        if (got_q.size() !== 2) begin
            errors++; $display("FAIL flush_count: got %0d want 2", got_q.size());
        end else begin
            checks++; if (got_q[0] !== 8'h5A) begin errors++; $display("FAIL flush_byte0: got %h want 5a", got_q[0]); end
            checks++; if (got_q[1] !== 8'h70) begin errors++; $display("FAIL flush_byte1: got %h want 70", got_q[1]); end
        end
        checks++;
        if (bytes_written !== 32'd2) begin
            errors++; $display("FAIL flush_bytes_written: got %0d want 2", bytes_written);
        end
        // Back in IDLE: a valid sample is flagged and not written.
        drive_one(12'h111);
        tick();
        checks++;
        if (fifo_error_stat !== 8'h04) begin
            errors++; $display("FAIL idle_sample_err: got %h want 04", fifo_error_stat);
        end
        checks++;
        if (got_q.size() !== 2) begin
            errors++; $display("FAIL idle_sample_written: got %0d bytes want 2", got_q.size());
        end
        pulse_clear();
        checks++;
        if (fifo_error_stat !== 8'h00) begin
            errors++; $display("FAIL idle_clear: got %h want 00", fifo_error_stat);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] s;
        acc_q.delete();
        do_arm(1'b1, 1'b0);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s = 12'($urandom_range(0, 4095));
            if (i < 4) acc_q.push_back(s);
            drive_one(s);
        end
        tick();
        checks++;
        if (fifo_error_stat !== 8'h01) begin
            errors++; $display("FAIL bp_err: got %h want 01", fifo_error_stat);
        end
        checks++;
        if (got_q.size() !== 0) begin
            errors++; $display("FAIL bp_write_while_full: got %0d bytes want 0", got_q.size());
        end
        fifo_full = 1'b0;
        disarm_wait();
        model_pack(1'b1, 1'b0);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL bp_byte%0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
        pulse_clear();
    endtask

    task automatic test_overrun();
        do_arm(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            adc_data  = 12'($urandom_range(0, 4095));
            adc_valid = 1'b1;
            tick();
        end
        adc_valid = 1'b0;
        checks++;
        if (fifo_error_stat !== 8'h02) begin
            errors++; $display("FAIL overrun_err: got %h want 02", fifo_error_stat);
        end
        disarm_wait();
        pulse_clear();
        checks++;
        if (fifo_error_stat !== 8'h00) begin
            errors++; $display("FAIL overrun_clear: got %h want 00", fifo_error_stat);
        end
        // Fill the queue behind a full FIFO, then drop a sample in the very
        // cycle the clear pulse arrives.
        acc_q.delete();
        do_arm(1'b0, 1'b0);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc_q.push_back(12'($urandom_range(0, 4095)));
            drive_one(acc_q[i]);
            tick();
        end
        fifo_full         = 1'b0;
        clear_fifo_errors = 1'b1;
        drive_one(12'hFFF);
        clear_fifo_errors = 1'b0;
        checks++;
        if (fifo_error_stat !== 8'h02) begin
            errors++; $display("FAIL set_beats_clear: got %h want 02", fifo_error_stat);
        end
        disarm_wait();
        model_pack(1'b0, 1'b0);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL drop_stream_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL drop_stream_byte%0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
        pulse_clear();
    endtask

    task automatic test_segments();
        orphan_seg = 0;
        stream_segment_size = 32'd3;
        do_arm(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) drive_one(12'($urandom_range(0, 4095)));
        disarm_wait();
        checks++;
        if (got_q.size() !== 7) begin
            errors++; $display("FAIL seg_count: got %0d want 7", got_q.size());
        end
        for (int k = 0; k < 7 && k < seg_q.size(); k++) begin
            checks++;
            if (seg_q[k] !== ((k + 1) % 3 == 0)) begin
                errors++; $display("FAIL seg_flag_write%0d: got %b want %b", k + 1, seg_q[k], ((k + 1) % 3 == 0));
            end
        end
        checks++;
        if (orphan_seg !== 0) begin
            errors++; $display("FAIL seg_without_write: got %0d want 0", orphan_seg);
        end
        stream_segment_size = 32'd0;
    endtask

    task automatic test_async_reset();
        int n_before;
        drive_one(12'h0AA);              // sample while idle -> bit 2
        do_arm(1'b1, 1'b0);
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) drive_one(12'($urandom_range(0, 4095)));
        fifo_full = 1'b0;
        tick();
        tick();
        @(posedge clk_adc);
        #3 reset_n = 1'b0;
        #1;
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL areset_wr_en: got %b want 0", fifo_wr_en); end
        checks++; if (fifo_wr_data !== 8'h00) begin errors++; $display("FAIL areset_wr_data: got %h want 00", fifo_wr_data); end
        checks++; if (fifo_error_stat !== 8'h00) begin errors++; $display("FAIL areset_err: got %h want 00", fifo_error_stat); end
        checks++; if (segment_done !== 1'b0) begin errors++; $display("FAIL areset_seg: got %b want 0", segment_done); end
        checks++; if (bytes_written !== 32'd0) begin errors++; $display("FAIL areset_bytes: got %0d want 0", bytes_written); end
        arm_i = 1'b0;
        #3 reset_n = 1'b1;
        n_before = got_q.size();
        repeat (8) tick();
        checks++;
        if (got_q.size() !== n_before) begin
            errors++; $display("FAIL areset_queue_discard: got %0d bytes want %0d", got_q.size(), n_before);
        end
    endtask

    initial begin
        reset_n             = 1'b0;
        arm_i               = 1'b0;
        adc_data            = '0;
        adc_valid           = 1'b0;
        low_res             = 1'b0;
        low_res_lsb         = 1'b0;
        stream_segment_size = 32'd0;
        clear_fifo_errors   = 1'b0;
        fifo_full           = 1'b0;

        test_reset();
        test_lowres(1'b0);
        test_lowres(1'b1);
        test_pack12();
        test_odd_flush();
        test_backpressure();
        test_overrun();
        test_segments();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
